// File: rtl/chip8_vga_scaler_if.sv
// Framebuffer read port between the VGA scaler (master) and the display RAM (slave).
interface chip8_vga_scaler_if #(
    parameter int AW = 13
);
    logic [AW-1:0] fb_request_addr;
    logic          fb_rd_en;
    logic          fb_pixel_data;

    modport master (output fb_request_addr, output fb_rd_en, input fb_pixel_data);
    modport slave  (input fb_request_addr, input fb_rd_en, output fb_pixel_data);
endinterface

// File: rtl/chip8_vga_scaler.sv
// 640x480 VGA raster generator that centres a scaled 64x32 / 128x64 Chip8 framebuffer
// window and aligns the pixel colour with a framebuffer RAM of RD_LAT cycles latency.
module chip8_vga_scaler #(
    parameter int          FB_W       = 64,
    parameter int          FB_H       = 32,
    parameter int          SCALE_LOG2 = 3,
    parameter int          WIN_LEFT   = 64,
    parameter int          WIN_TOP    = 112,
    parameter int          RD_LAT     = 1,
    parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB     = 24'h0000FF,
    parameter int          AW         = $clog2(4 * FB_W * FB_H),
    parameter int          H_VISIBLE  = 1280,
    parameter int          H_SYNC_BEG = 1312,
    parameter int          H_SYNC_END = 1504,
    parameter int          H_TOTAL    = 1600,
    parameter int          V_VISIBLE  = 480,
    parameter int          V_SYNC_BEG = 490,
    parameter int          V_SYNC_END = 492,
    parameter int          V_TOTAL    = 525
) (
    input  logic                clk50,
    input  logic                reset_n,
    input  logic                hires_req,
    chip8_vga_scaler_if.master  fb,
    output logic                hires,
    output logic                frame_start,
    output logic [7:0]          VGA_R,
    output logic [7:0]          VGA_G,
    output logic [7:0]          VGA_B,
    output logic                VGA_CLK,
    output logic                VGA_HS,
    output logic                VGA_VS,
    output logic                VGA_BLANK_n,
    output logic                VGA_SYNC_n
);
    localparam int         FBW_LOG2 = $clog2(FB_W);
    localparam int         S_LO     = SCALE_LOG2;
    localparam int         S_HI     = SCALE_LOG2 - 1;
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
    localparam logic [10:0] H_SB    = 11'(H_SYNC_BEG);
    localparam logic [10:0] H_SE    = 11'(H_SYNC_END);
    localparam logic [9:0]  V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0]  V_SB    = 10'(V_SYNC_BEG);
    localparam logic [9:0]  V_SE    = 10'(V_SYNC_END);
    localparam logic [9:0]  WIN_L   = 10'(WIN_LEFT);
    localparam logic [9:0]  WIN_R   = 10'(WIN_LEFT + (FB_W << SCALE_LOG2));
    localparam logic [9:0]  WIN_T   = 10'(WIN_TOP);
    localparam logic [9:0]  WIN_B   = 10'(WIN_TOP + (FB_H << SCALE_LOG2));

    // Delay-line bit positions
    localparam int B_WIN = 0;
    localparam int B_HS  = 1;
    localparam int B_VS  = 2;
    localparam int B_VIS = 3;
    localparam int B_CLK = 4;

    logic [10:0]   hcount_q, hcount_d;
    logic [9:0]    vcount_q, vcount_d;
    logic          started_q, started_d;
    logic          hires_q, hires_d;
    logic          frame_start_q, frame_start_d;
    logic [4:0]    pipe_q [RD_LAT];
    logic [4:0]    stage_in_s;
    logic [4:0]    tap_s;
    logic [9:0]    px_s, dx_s, dy_s;
    logic          in_win_s;
    logic [AW-1:0] addr_s;
    logic [23:0]   rgb_d, rgb_q;
    logic          hs_q, vs_q, blank_n_q, vclk_q;

    // Raster counters; the first edge after reset only arms the raster so the frame starts at (0,0)
    always_comb begin
        hcount_d  = hcount_q;
        vcount_d  = vcount_q;
        hires_d   = hires_q;
        started_d = 1'b1;
        if (!started_q) begin
            hcount_d = 11'd0;
            vcount_d = 10'd0;
        end else if (hcount_q == H_LAST) begin
            hcount_d = 11'd0;
            if (vcount_q == V_LAST) begin
                vcount_d = 10'd0;
                hires_d  = hires_req;
            end else begin
                vcount_d = vcount_q + 10'd1;
            end
        end else begin
            hcount_d = hcount_q + 11'd1;
        end
        frame_start_d = (hcount_d == 11'd0) && (vcount_d == 10'd0);
    end

    // Counter, mode and frame-start state
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 10'd0;
            started_q     <= 1'b0;
            hires_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            started_q     <= started_d;
            hires_q       <= hires_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Window decode and row-major cell address using shifts only
    always_comb begin
        px_s     = hcount_q[10:1];
        dx_s     = px_s - WIN_L;
        dy_s     = vcount_q - WIN_T;
        in_win_s = started_q && (px_s >= WIN_L) && (px_s < WIN_R) &&
                   (vcount_q >= WIN_T) && (vcount_q < WIN_B);
        addr_s   = {AW{1'b0}};
        if (!in_win_s) begin
            addr_s = {AW{1'b0}};
        end else if (hires_q) begin
            addr_s = (AW'(dy_s >> S_HI) << (FBW_LOG2 + 1)) | AW'(dx_s >> S_HI);
        end else begin
            addr_s = (AW'(dy_s >> S_LO) << FBW_LOG2) | AW'(dx_s >> S_LO);
        end
    end

    // Raw timing flags; idle until the raster is armed so the delay line never shows reset-time junk
    always_comb begin
        stage_in_s = 5'b00000;
        if (started_q) begin
            stage_in_s[B_WIN] = in_win_s;
            stage_in_s[B_HS]  = (hcount_q >= H_SB) && (hcount_q < H_SE);
            stage_in_s[B_VS]  = (vcount_q >= V_SB) && (vcount_q < V_SE);
            stage_in_s[B_VIS] = (hcount_q < H_VIS) && (vcount_q < V_VIS);
            stage_in_s[B_CLK] = hcount_q[0];
        end else begin
            stage_in_s = 5'b00000;
        end
    end

    // RD_LAT-deep delay line matching the framebuffer read latency
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= 5'b00000;
            end
        end else begin
            pipe_q[0] <= stage_in_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Colour select from the delayed window flag and the returned RAM bit
    always_comb begin
        tap_s = pipe_q[RD_LAT-1];
        rgb_d = 24'h000000;
        if (!tap_s[B_WIN]) begin
            rgb_d = 24'h000000;
        end else if (fb.fb_pixel_data) begin
            rgb_d = FG_RGB;
        end else begin
            rgb_d = BG_RGB;
        end
    end

    // Registered VGA pins
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q     <= 24'h000000;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            vclk_q    <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            hs_q      <= ~tap_s[B_HS];
            vs_q      <= ~tap_s[B_VS];
            blank_n_q <= tap_s[B_VIS];
            vclk_q    <= tap_s[B_CLK];
        end
    end

    assign fb.fb_request_addr = addr_s;
    assign fb.fb_rd_en        = in_win_s;
    assign hires              = hires_q;
    assign frame_start        = frame_start_q;
    assign VGA_R              = rgb_q[23:16];
    assign VGA_G              = rgb_q[15:8];
    assign VGA_B              = rgb_q[7:0];
    assign VGA_HS             = hs_q;
    assign VGA_VS             = vs_q;
    assign VGA_BLANK_n        = blank_n_q;
    assign VGA_CLK            = vclk_q;
    assign VGA_SYNC_n         = 1'b1;
endmodule

// File: tb/tb_chip8_vga_scaler.sv
// Bench: one full-size instance for 640x480 line timing, two compact-raster instances
// (RD_LAT 1 and 3) with checkerboard RAM models for addressing, colour, mode and reset.
`timescale 1ns/1ps
module tb_chip8_vga_scaler;
    localparam int SH_TOT = 128;
    localparam int SFRAME = 128 * 30;
    localparam int T_RST  = 2 * SFRAME + 12 * SH_TOT + 40;

    logic clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    logic reset_n;
    logic hires_req;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tcyc;

    chip8_vga_scaler_if #(.AW(13)) fb0 ();
    chip8_vga_scaler_if #(.AW(7))  fb1 ();
    chip8_vga_scaler_if #(.AW(7))  fb3 ();

    logic       h0, fs0, c0, hs0, vs0, bl0, sy0;
    logic [7:0] r0, g0, b0;
    logic       h1, fs1, c1, hs1, vs1, bl1, sy1;
    logic [7:0] r1, g1, b1;
    logic       h3, fs3, c3, hs3, vs3, bl3, sy3;
    logic [7:0] r3, g3, b3;

    chip8_vga_scaler u_d0 (
        .clk50(clk50), .reset_n(reset_n), .hires_req(hires_req), .fb(fb0),
        .hires(h0), .frame_start(fs0), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
        .VGA_CLK(c0), .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_n(bl0), .VGA_SYNC_n(sy0));

    chip8_vga_scaler #(.FB_W(8), .FB_H(4), .SCALE_LOG2(2), .WIN_LEFT(8), .WIN_TOP(4), .RD_LAT(1),
        .AW(7), .H_VISIBLE(96), .H_SYNC_BEG(104), .H_SYNC_END(120), .H_TOTAL(128),
        .V_VISIBLE(24), .V_SYNC_BEG(26), .V_SYNC_END(28), .V_TOTAL(30)) u_s1 (
        .clk50(clk50), .reset_n(reset_n), .hires_req(hires_req), .fb(fb1),
        .hires(h1), .frame_start(fs1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
        .VGA_CLK(c1), .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_n(bl1), .VGA_SYNC_n(sy1));

    chip8_vga_scaler #(.FB_W(8), .FB_H(4), .SCALE_LOG2(2), .WIN_LEFT(8), .WIN_TOP(4), .RD_LAT(3),
        .AW(7), .H_VISIBLE(96), .H_SYNC_BEG(104), .H_SYNC_END(120), .H_TOTAL(128),
        .V_VISIBLE(24), .V_SYNC_BEG(26), .V_SYNC_END(28), .V_TOTAL(30)) u_s3 (
        .clk50(clk50), .reset_n(reset_n), .hires_req(hires_req), .fb(fb3),
        .hires(h3), .frame_start(fs3), .VGA_R(r3), .VGA_G(g3), .VGA_B(b3),
        .VGA_CLK(c3), .VGA_HS(hs3), .VGA_VS(vs3), .VGA_BLANK_n(bl3), .VGA_SYNC_n(sy3));

    // RAM content: checkerboard in the lo-res layout (bit 0 = cell column, bit 3 = cell row)
    function automatic logic pat(input int a);
        return logic'(((a & 1) ^ ((a >> 3) & 1)) != 0);
    endfunction

    logic       ram1_q;
    logic [2:0] ram3_q;
    always @(posedge clk50) begin
        ram1_q <= pat(int'(fb1.fb_request_addr));
        ram3_q <= {ram3_q[1:0], pat(int'(fb3.fb_request_addr))};
    end
    assign fb0.fb_pixel_data = 1'b0;
    assign fb1.fb_pixel_data = ram1_q;
    assign fb3.fb_pixel_data = ram3_q[2];

    // Bench cycle index: 0 is the first cycle in which the counters read (0,0)
    always @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) tcyc <= -1;
        else          tcyc <= tcyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tcyc=%0d)", tag, got, exp, tcyc);
        end
    endtask

    function automatic bit in_win(input int pos);
        int line, px;
        line = pos / SH_TOT;
        px   = (pos % SH_TOT) / 2;
        return (px >= 8) && (px < 40) && (line >= 4) && (line < 20);
    endfunction

    function automatic int exp_addr(input int pos, input bit hi);
        int line, px, sc, w;
        line = pos / SH_TOT;
        px   = (pos % SH_TOT) / 2;
        sc   = hi ? 2 : 4;
        w    = hi ? 16 : 8;
        if (!in_win(pos)) return 0;
        return ((line - 4) / sc) * w + (px - 8) / sc;
    endfunction

    task automatic chk_rst(input string tag, input logic [7:0] r, g, b, input logic hs, vs, bl, c, sy,
                           fs, rd, hi, input logic [12:0] addr);
        check_eq({tag, "_rgb"}, {r, g, b}, 32'h0);
        check_eq({tag, "_hs"}, hs, 1'b1);
        check_eq({tag, "_vs"}, vs, 1'b1);
        check_eq({tag, "_blank_n"}, bl, 1'b0);
        check_eq({tag, "_vga_clk"}, c, 1'b0);
        check_eq({tag, "_sync_n"}, sy, 1'b1);
        check_eq({tag, "_fstart"}, fs, 1'b0);
        check_eq({tag, "_rd_en"}, rd, 1'b0);
        check_eq({tag, "_hires"}, hi, 1'b0);
        check_eq({tag, "_addr"}, addr, 32'h0);
    endtask

    task automatic chk_all_rst(input string tag);
        chk_rst({tag, "_d0"}, r0, g0, b0, hs0, vs0, bl0, c0, sy0, fs0, fb0.fb_rd_en, h0, fb0.fb_request_addr);
        chk_rst({tag, "_s1"}, r1, g1, b1, hs1, vs1, bl1, c1, sy1, fs1, fb1.fb_rd_en, h1, 13'(fb1.fb_request_addr));
        chk_rst({tag, "_s3"}, r3, g3, b3, hs3, vs3, bl3, c3, sy3, fs3, fb3.fb_rd_en, h3, 13'(fb3.fb_request_addr));
    endtask

    // Per-cycle check of one compact instance: address side now, pins RD_LAT+1 cycles later
    task automatic chk_small(input string tag, input int lat, input int t, input logic [7:0] r, g, b,
                             input logic hs, vs, bl, c, fs, hi_o, rd, input logic [6:0] addr);
        int p, pos, line, h;
        bit hi;
        logic [23:0] e_rgb;
        logic e_hs, e_vs, e_bl, e_c;
        pos = t % SFRAME;
        hi  = (t >= SFRAME);
        check_eq({tag, "_rd_en"}, rd, in_win(pos));
        check_eq({tag, "_addr"}, addr, exp_addr(pos, hi));
        check_eq({tag, "_hires"}, hi_o, hi);
        check_eq({tag, "_fstart"}, fs, pos == 0);
        p = t - lat - 1;
        if (p < 0) begin
            e_rgb = 24'h0; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_c = 1'b0;
        end else begin
            pos  = p % SFRAME;
            hi   = (p >= SFRAME);
            line = pos / SH_TOT;
            h    = pos % SH_TOT;
            e_rgb = !in_win(pos) ? 24'h000000 : (pat(exp_addr(pos, hi)) ? 24'hFFFFFF : 24'h0000FF);
            e_hs  = !((h >= 104) && (h < 120));
            e_vs  = !((line >= 26) && (line < 28));
            e_bl  = (h < 96) && (line < 24);
            e_c   = h[0];
        end
        check_eq({tag, "_rgb"}, {r, g, b}, e_rgb);
        check_eq({tag, "_hs"}, hs, e_hs);
        check_eq({tag, "_vs"}, vs, e_vs);
        check_eq({tag, "_blank_n"}, bl, e_bl);
        check_eq({tag, "_vga_clk"}, c, e_c);
    endtask

    initial begin
        int hs_low, bl_high, first_hs, t, p;
        hs_low = 0; bl_high = 0; first_hs = -1;
        reset_n   = 1'b0;
        hires_req = 1'b0;
        repeat (3) @(negedge clk50);
        chk_all_rst("rst");
        reset_n = 1'b1;

        for (int k = 0; k <= T_RST; k++) begin
            @(negedge clk50);
            t = tcyc;
            if (t == 10 * SH_TOT) hires_req = 1'b1;
            chk_small("s1", 1, t, r1, g1, b1, hs1, vs1, bl1, c1, fs1, h1, fb1.fb_rd_en, fb1.fb_request_addr);
            chk_small("s3", 3, t, r3, g3, b3, hs3, vs3, bl3, c3, fs3, h3, fb3.fb_rd_en, fb3.fb_request_addr);
            if (t < 1610) begin
                p = t - 2;
                check_eq("d0_fstart", fs0, t == 0);
                check_eq("d0_rd_en", fb0.fb_rd_en, 1'b0);
                check_eq("d0_hs", hs0, (p < 0) ? 1'b1 : !((p % 1600 >= 1312) && (p % 1600 < 1504)));
                check_eq("d0_blank_n", bl0, (p >= 0) && (p % 1600 < 1280));
                check_eq("d0_vga_clk", c0, (p >= 0) && (t % 2 == 1));
                if (t >= 10) begin
                    if (hs0 == 1'b0) hs_low++;
                    if (bl0 == 1'b1) bl_high++;
                    if (hs0 == 1'b0 && first_hs < 0) first_hs = t;
                end
            end
            case (t)
                528:  begin check_eq("lo_first_rd", fb1.fb_rd_en, 1'b1); check_eq("lo_first_addr", fb1.fb_request_addr, 7'd0); end
                526:  begin check_eq("lo_left_rd", fb1.fb_rd_en, 1'b0); check_eq("lo_left_addr", fb1.fb_request_addr, 7'd0); end
                1048: check_eq("lo_cell11", fb1.fb_request_addr, 7'd9);
                2510: check_eq("lo_last", fb3.fb_request_addr, 7'd31);
                2512: check_eq("lo_right_rd", fb3.fb_rd_en, 1'b0);
                3839: check_eq("hires_hold", h1, 1'b0);
                3840: check_eq("hires_load", h3, 1'b1);
                4628: check_eq("hi_cell11", fb1.fb_request_addr, 7'd17);
                6350: check_eq("hi_last", fb3.fb_request_addr, 7'd127);
                default: ;
            endcase
        end
        check_eq("d0_hs_low_cycles", hs_low, 192);
        check_eq("d0_blank_hi_cycles", bl_high, 1280);
        check_eq("d0_hs_first_low", first_hs, 1314);

        // Mid-frame reset while hi-res and inside the window
        check_eq("pre_rst_rd_en", fb1.fb_rd_en, 1'b1);
        check_eq("pre_rst_addr", fb1.fb_request_addr, 7'd70);
        #2 reset_n = 1'b0;
        #1 chk_all_rst("midrst");
        repeat (3) @(negedge clk50);
        chk_all_rst("midrst_hold");
        reset_n = 1'b1;
        @(negedge clk50);
        check_eq("rel_fstart_s1", fs1, 1'b1);
        check_eq("rel_fstart_d0", fs0, 1'b1);
        check_eq("rel_hires_s1", h1, 1'b0);
        check_eq("rel_hires_s3", h3, 1'b0);
        @(negedge clk50);
        check_eq("rel_fstart_end", fs3, 1'b0);
        check_eq("rel_hires_after", h1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/chip8_vga_scaler.md
# chip8_vga_scaler

Parametrised VGA raster generator and framebuffer scaler for the Chip8 display path. It produces 640x480 VGA timing from the 50 MHz clock and centres a scaled framebuffer window on screen. It drives a read address into a framebuffer RAM of configurable read latency and supports both 64x32 (lo-res) and 128x64 (SCHIP hi-res) framebuffers. Resolution switches only at frame boundaries. It sits between the framebuffer RAM and the VGA DAC pins.

## Interface
- FB_W, 64, lo-res framebuffer width in cells (power of two)
- FB_H, 32, lo-res framebuffer height in cells (power of two)
- SCALE_LOG2, 3, lo-res scale = 2^SCALE_LOG2 VGA pixels per cell; hi-res uses SCALE_LOG2-1 (must be ≥1)
- WIN_LEFT, 64, window left edge, VGA pixel column
- WIN_TOP, 112, window top edge, VGA line
- RD_LAT, 1, framebuffer read latency in clk50 cycles (1..3)
- FG_RGB, 24'hFFFFFF, colour of set cell
- BG_RGB, 24'h0000FF, colour of clear cell inside window
- AW, log2(4·FB_W·FB_H) = 13, address width

Ports:
- clk50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- hires_req  in  1  requested mode (1 = hi-res); sampled once per frame
- fb_pixel_data  in  1  RAM read data, valid RD_LAT cycles after address
- fb_request_addr  out  AW  cell address, row-major
- fb_rd_en  out  1  high while the address refers to an in-window pixel
- hires  out  1  mode currently displayed
- frame_start  out  1  one-cycle pulse at hcount=0, vcount=0
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
- VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n  out  1 each  DAC/VGA control

## Operation
- Reset is asynchronous and active-low on every flop.
- hcount, 11 bits, counts 0..1599 and wraps. vcount, 10 bits, increments on the hcount wrap and counts 0..524.
- Pixel column px = hcount[10:1]. Each VGA pixel lasts 2 clk50 cycles.
- Raw timing signals, before the pipeline:
  - HS low for hcount 1312..1503.
  - VS low for vcount 490..491.
  - BLANK_n high iff hcount<1280 and vcount<480.
  - VGA_CLK = hcount[0].
  - VGA_SYNC_n is constant 1.
- Mode and scale: S = SCALE_LOG2 in lo-res, SCALE_LOG2-1 in hi-res. W = FB_W or 2·FB_W. H = FB_H or 2·FB_H.
- Window: WIN_LEFT ≤ px < WIN_LEFT+FB_W·2^SCALE_LOG2 and WIN_TOP ≤ vcount < WIN_TOP+FB_H·2^SCALE_LOG2. The window size is identical in both modes.
- Address: ((vcount−WIN_TOP)>>S)·W + ((px−WIN_LEFT)>>S). It is computed with shifts only, no multiplier.
  - Outside the window, fb_request_addr=0 and fb_rd_en=0.
  - Address and rd_en are combinational from the counter registers.
- Mode register: hires loads hires_req on the last cycle of a frame (hcount=1599, vcount=524) and is otherwise held. A mid-frame hires_req change has no effect until the next frame.
- Colour: in window and data=1 gives FG_RGB; in window and data=0 gives BG_RGB; outside window gives 0.

## Timing
- Read alignment: the in-window flag, HS, VS, BLANK_n and VGA_CLK pass through an RD_LAT-stage delay. Colour is then selected using fb_pixel_data.
- All VGA outputs are registered. Counter state at cycle t appears on the pins at t+RD_LAT+1.
- frame_start is asserted in the cycle the counters read (0,0). It is not delayed.
- Reset values:
  - hcount=0, vcount=0, hires=0, all delay stages cleared.
  - VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_n=0, VGA_CLK=0, VGA_SYNC_n=1.
  - frame_start=0, fb_rd_en=0, fb_request_addr=0.
- First valid frame starts at the first clk50 edge after reset_n deasserts.
- Reset mid-frame: outputs take reset values immediately (asynchronously), counters restart at (0,0), and the mode returns to lo-res.

## Test plan
- Reset and sync timing:
  - Stimulus: hold reset_n=0, release, run 2 frames.
  - Required: during reset, outputs at the listed reset values. HS low for exactly 192 cycles per 1600. VS low for 2 lines per 525. BLANK_n high for 1280 cycles on lines 0..479.
- Lo-res addressing:
  - Stimulus: counters at px=64, line 112.
  - Required: addr 0, rd_en=1.
  - Further points: px=575, line 367 gives addr 2047; px=63 gives rd_en=0, addr 0; px=72, line 120 gives addr 65.
- Hi-res addressing:
  - Stimulus: hires=1.
  - Required: px=575, line 367 gives addr 8191; px=68, line 116 gives addr 129.
- Latency alignment:
  - Stimulus: RD_LAT=1 and RD_LAT=3, each with a RAM model of matching latency and a checkerboard pattern.
  - Required: white/blue boundaries fall exactly every 16 cycles, in phase with the delayed BLANK_n. No pixel is smeared into the border, and the border reads 0.
- Mode switch:
  - Stimulus: raise hires_req mid-frame at line 200.
  - Required: hires stays 0 until after hcount=1599, vcount=524, then reads 1. Addressing of the following frame uses the hi-res formula.
- Reset mid-operation:
  - Stimulus: hires=1, pull reset_n low at line 300.
  - Required: outputs reset immediately. After release, frame_start pulses at cycle 0 and hires=0.
